// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and helpers for the 7-segment display controller.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam int DP_BIT = 7;

  localparam logic [7:0] SEG_LUT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  localparam logic [3:0] COM_PATTERN [0:3] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  // Tens or ones digit of a 7-bit value, taken mod 100.
  function automatic logic [3:0] dec_digit(
    input logic [6:0] v,
    input logic       tens
  );
    logic [6:0] m;
    logic [6:0] q;
    m = v % 7'd100;
    q = tens ? (m / 7'd10) : (m % 7'd10);
    return q[3:0];
  endfunction

endpackage

// File: rtl/fnd_bcd_to_seg.sv
// fnd_bcd_to_seg: one decimal digit plus dp to active-low segments.
// Codes 10..15 blank the whole digit, dp included.
module fnd_bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  // LUT lookup; dp driven low when lit.
  always_comb begin
    o_seg = 8'hFF;
    if (i_digit <= 4'd9) begin
      o_seg         = SEG_LUT[i_digit];
      o_seg[DP_BIT] = ~i_dp;
    end
  end

endmodule

// File: rtl/fnd_controller.sv
// fnd_controller: 4-digit multiplexed display of SS.CC or HH.MM.
// Optional DOT_BLINK_EN: separator dp lit only while msec < 50.
module fnd_controller
  import fnd_pkg::*;
#(
  parameter int SCAN_COUNT = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_mode,
  input  logic [6:0] msec,
  input  logic [6:0] sec,
  input  logic [6:0] min,
  input  logic [6:0] hour,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int CW = $clog2(SCAN_COUNT);
  localparam logic [CW-1:0] LAST = CW'(SCAN_COUNT - 1);

  logic [CW-1:0] r_cnt;
  digit_idx_t    r_idx;
  logic          w_tick;
  logic [6:0]    w_low;
  logic [6:0]    w_high;
  logic [3:0]    w_digit;
  logic          w_dp;
  logic [7:0]    w_seg;

  assign w_tick = (r_cnt == LAST);

  // Slot timer: wraps every SCAN_COUNT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end

  // Digit index advances once per slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_idx <= '0;
    else if (w_tick) r_idx <= r_idx + 1'b1;
  end

  // Field select, digit split and separator dp for the current slot.
  always_comb begin
    w_low   = sel_mode ? min : msec;
    w_high  = sel_mode ? hour : sec;
    w_digit = 4'd0;
    unique case (r_idx)
      2'd0: w_digit = dec_digit(w_low, 1'b0);
      2'd1: w_digit = dec_digit(w_low, 1'b1);
      2'd2: w_digit = dec_digit(w_high, 1'b0);
      2'd3: w_digit = dec_digit(w_high, 1'b1);
    endcase
`ifdef DOT_BLINK_EN
    w_dp = (r_idx == 2'd2) && (msec < 7'd50);
`else
    w_dp = (r_idx == 2'd2);
`endif
  end

  fnd_bcd_to_seg u_seg (
    .i_digit (w_digit),
    .i_dp    (w_dp),
    .o_seg   (w_seg)
  );

  // Registered outputs, com and data aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnd_com  <= 4'b1111;
      fnd_data <= 8'hFF;
    end else begin
      fnd_com  <= COM_PATTERN[r_idx];
      fnd_data <= w_seg;
    end
  end

endmodule
